sec_counter_bcd: RTL

Seconds counter for the stopwatch display path. Divides the system clock down to a 1 s tick and counts 00–59 in BCD. Start/stop and clear come from raw push-buttons. Q_tens (0–5) drives the tens-digit seven-segment decoder; Q_ones (0–9) drives the ones-digit decoder; carry feeds a future minutes stage.

---
 rtl/sec_counter_bcd.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sec_counter_bcd.sv
// Stopwatch seconds stage: prescales clk down to a one-second tick and
// counts 00-59 in BCD, with start/stop and clear coming from raw buttons.
// Every output is a flop, so nothing combinational runs from the buttons
// to the display decoders or the minutes stage.
module sec_counter_bcd #(
   parameter int TICK_DIV = 100000000,
   parameter int CNT_W    = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] Q_ones,
   output logic [2:0] Q_tens,
   output logic       running,
   output logic       carry
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int         BTN_N       = 2;
   localparam int         BTN_SS      = 0;
   localparam int         BTN_CLR     = 1;
   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

   logic [BTN_N-1:0] btn_raw;
   logic [BTN_N-1:0] btn_press;

   assign btn_raw = {clear, start_stop};

   // Each button gets a two-flop synchroniser followed by a history flop.
   // A press is the first cycle the synchronised level is seen high, so
   // holding a button down yields exactly one press.
   genvar gi;
   generate
      for (gi = 0; gi < BTN_N; gi++) begin : g_btn
         logic sync1_q;
         logic sync2_q;
         logic prev_q;

         // synchronise the raw level and remember the previous sample
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               prev_q  <= 1'b0;
            end else begin
               sync1_q <= btn_raw[gi];
               sync2_q <= sync1_q;
               prev_q  <= sync2_q;
            end
         end

         assign btn_press[gi] = sync2_q & ~prev_q;
      end
   endgenerate

   logic       ss_press;
   logic       clr_press;

   assign ss_press  = btn_press[BTN_SS];
   assign clr_press = btn_press[BTN_CLR];

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] presc_q,   presc_d;
   logic [3:0]       ones_q,    ones_d;
   logic [2:0]       tens_q,    tens_d;
   logic             carry_q,   carry_d;
   logic             running_q, running_d;
   logic             tick;

   // The tick is the last prescaler cycle of a second, and only while running.
   assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

   // register state, prescaler, digits and the registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         ones_q    <= 4'd0;
         tens_q    <= 3'd0;
         carry_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         ones_q    <= ones_d;
         tens_q    <= tens_d;
         carry_q   <= carry_d;
         running_q <= running_d;
      end
   end

   // next state, prescaler and digit update; clear overrides everything
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      ones_d  = ones_q;
      tens_d  = tens_q;
      carry_d = 1'b0;

      if (clr_press) begin
         // Clear drops any start_stop press and any tick due this cycle.
         state_d = IDLE;
         presc_d = '0;
         ones_d  = 4'd0;
         tens_d  = 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ss_press) begin
                  state_d = RUN;
                  presc_d = '0;
               end
            end
            RUN: begin
               presc_d = tick ? '0 : presc_q + CNT_W'(1);
               // Counting is applied before a pause on the same edge,
               // so a stop coinciding with a tick still takes the step.
               if (tick) begin
                  if (ones_q >= 4'd9) begin
                     ones_d = 4'd0;
                     if (tens_q >= 3'd5) begin
                        tens_d  = 3'd0;
                        carry_d = 1'b1;
                     end else begin
                        tens_d = tens_q + 3'd1;
                     end
                  end else begin
                     ones_d = ones_q + 4'd1;
                  end
               end
               if (ss_press) begin
                  state_d = PAUSE;
               end
            end
            PAUSE: begin
               // Prescaler is left untouched so the partial second resumes.
               if (ss_press) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
               presc_d = '0;
               ones_d  = 4'd0;
               tens_d  = 3'd0;
            end
         endcase
      end

      running_d = (state_d == RUN);
   end

   assign Q_ones  = ones_q;
   assign Q_tens  = tens_q;
   assign running = running_q;
   assign carry   = carry_q;

endmodule
